// File: rtl/fetch_pc_unit.sv
// PC and instruction-fetch stage: fetches one instruction, holds it through execute,
// then steps to the selected next PC. A misaligned target traps until reset.
module fetch_pc_unit #(
  parameter int          XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int          INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           pc_src,
  input  logic [XLEN-1:0]      pc_plus_imm,
  input  logic [XLEN-1:0]      jalr_target,
  input  logic                 commit,
  output logic                 imem_req,
  output logic [XLEN-1:0]      imem_addr,
  input  logic                 imem_ready,
  input  logic [31:0]          imem_rdata,
  output logic [31:0]          instr,
  output logic                 instr_valid,
  output logic [XLEN-1:0]      pc,
  output logic [XLEN-1:0]      pc_plus4,
  output logic                 trap,
  output logic [XLEN-1:0]      trap_addr,
  output logic [INSTRET_W-1:0] instret
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, TRAP} state_t;

  state_t                state_q;
  logic [XLEN-1:0]       pc_q;
  logic [31:0]           instr_q;
  logic                  req_q;
  logic                  valid_q;
  logic                  trap_q;
  logic [XLEN-1:0]       trap_addr_q;
  logic [INSTRET_W-1:0]  instret_q;
  logic [XLEN-1:0]       target_d;

  assign pc_plus4 = pc_q + XLEN'(4);

  // jalr clears bit 0 as the ISA requires; pc_src 11 falls back to sequential
  always_comb begin
    target_d = pc_plus4;
    case (pc_src)
      2'b01:   target_d = pc_plus_imm;
      2'b10:   target_d = {jalr_target[XLEN-1:1], 1'b0};
      default: target_d = pc_plus4;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      req_q       <= 1'b0;
      valid_q     <= 1'b0;
      trap_q      <= 1'b0;
      trap_addr_q <= '0;
      instret_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
        end
        FETCH: begin
          if (imem_ready) begin
            instr_q <= imem_rdata;
            state_q <= EXEC;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        EXEC: begin
          if (commit) begin
            valid_q <= 1'b0;
            if (target_d[1:0] != 2'b00) begin
              trap_q      <= 1'b1;
              trap_addr_q <= target_d;
              state_q     <= TRAP;
            end else begin
              pc_q      <= target_d;
              instret_q <= instret_q + INSTRET_W'(1);
              state_q   <= FETCH;
              req_q     <= 1'b1;
            end
          end
        end
        default: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign trap        = trap_q;
  assign trap_addr   = trap_addr_q;
  assign instret     = instret_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Transaction-level bench for fetch_pc_unit: each instruction is fetched (with optional
// stalls), executed and committed, and the expected next PC is computed from the ISA rules.
module tb_fetch_pc_unit;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  pc_src = 2'b00;
  logic [31:0] pc_plus_imm = '0, jalr_target = '0, imem_rdata = '0;
  logic        commit = 1'b0, imem_ready = 1'b0;
  logic        imem_req, instr_valid, trap;
  logic [31:0] imem_addr, instr, pc, pc_plus4, trap_addr, instret;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_pc, m_instret, m_instr;

  fetch_pc_unit #(.XLEN(32), .RESET_PC(RESET_PC), .INSTRET_W(32)) dut (
    .clk(clk), .rst(rst), .pc_src(pc_src), .pc_plus_imm(pc_plus_imm),
    .jalr_target(jalr_target), .commit(commit), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
    .trap(trap), .trap_addr(trap_addr), .instret(instret)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_target(input logic [1:0] src, input logic [31:0] cur,
                                             input logic [31:0] imm, input logic [31:0] jt);
    case (src)
      2'b01:   return imm;
      2'b10:   return jt & 32'hFFFF_FFFE;
      default: return cur + 32'd4;
    endcase
  endfunction

  // rst rises between edges so the checks below exercise the asynchronous path
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_vld", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", pc, RESET_PC);
    chk("rst_trap", trap, 0);
    chk("rst_trap_addr", trap_addr, 0);
    chk("rst_instret", instret, 0);
    @(posedge clk);
    #1;
    chk("rst_hold_instr", instr, 0);
    @(negedge clk);
    rst = 1'b0;
    imem_ready = 1'b0;
    commit = 1'b0;
    #1;
    chk("bubble_req", imem_req, 0);
    tick();
    chk("first_req", imem_req, 1);
    m_pc = RESET_PC;
    m_instret = 0;
    m_instr = 0;
  endtask

  task automatic do_instr(input int stall, input int hold, input logic [1:0] src,
                          input logic [31:0] imm, input logic [31:0] jt, input logic [31:0] data);
    logic [31:0] tgt;
    chk("fetch_req", imem_req, 1);
    chk("fetch_addr", imem_addr, m_pc);
    chk("fetch_vld", instr_valid, 0);
    for (int i = 0; i < stall; i++) begin
      imem_ready  = 1'b0;
      imem_rdata  = $urandom;
      commit      = 1'($urandom);
      pc_src      = 2'($urandom);
      pc_plus_imm = $urandom;
      jalr_target = $urandom;
      tick();
      chk("stall_req", imem_req, 1);
      chk("stall_addr", imem_addr, m_pc);
      chk("stall_vld", instr_valid, 0);
      chk("stall_pc", pc, m_pc);
    end
    commit     = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = data;
    tick();
    imem_ready = 1'b0;
    m_instr = data;
    chk("exec_vld", instr_valid, 1);
    chk("exec_instr", instr, m_instr);
    chk("exec_req", imem_req, 0);
    chk("exec_pc", pc, m_pc);
    chk("exec_pc4", pc_plus4, m_pc + 32'd4);
    for (int i = 0; i < hold; i++) begin
      commit     = 1'b0;
      imem_ready = 1'($urandom);
      imem_rdata = $urandom;
      tick();
      chk("hold_instr", instr, m_instr);
      chk("hold_vld", instr_valid, 1);
    end
    commit      = 1'b1;
    imem_ready  = 1'b0;
    pc_src      = src;
    pc_plus_imm = imm;
    jalr_target = jt;
    tgt = ref_target(src, m_pc, imm, jt);
    tick();
    commit = 1'b0;
    if (tgt[1:0] != 2'b00) begin
      chk("trap_flag", trap, 1);
      chk("trap_addr", trap_addr, tgt);
      chk("trap_pc", pc, m_pc);
      chk("trap_instret", instret, m_instret);
      chk("trap_vld", instr_valid, 0);
      chk("trap_req", imem_req, 0);
    end else begin
      m_pc = tgt;
      m_instret = m_instret + 1;
      chk("commit_pc", pc, m_pc);
      chk("commit_instret", instret, m_instret);
      chk("commit_vld", instr_valid, 0);
      chk("commit_trap", trap, 0);
      chk("commit_instr", instr, m_instr);
    end
  endtask

  initial begin
    #12;
    do_reset();

    for (int i = 0; i < 4; i++) do_instr(0, 0, 2'b00, '0, '0, 32'h0000_0013);
    chk("instret_after4", instret, 32'd4);
    do_instr(3, 1, 2'b00, '0, '0, 32'hDEAD_BEEF);
    chk("pc_after_stall", pc, 32'h14);

    do_reset();
    do_instr(0, 0, 2'b00, '0, '0, 32'h13);
    do_instr(0, 0, 2'b00, '0, '0, 32'h13);
    do_instr(0, 0, 2'b01, 32'h40, '0, 32'h0000_0063);
    chk("branch_pc", pc, 32'h40);
    do_instr(0, 2, 2'b10, '0, 32'h101, 32'h0000_0067);
    chk("jalr_pc", pc, 32'h100);
    chk("jalr_no_trap", trap, 0);
    do_instr(1, 0, 2'b11, 32'h3, 32'h7, 32'h13);
    chk("src11_pc", pc, 32'h104);
    do_instr(0, 0, 2'b01, 32'hFFFF_FFFC, '0, 32'h13);
    do_instr(0, 0, 2'b00, '0, '0, 32'h13);
    chk("wrap_pc", pc, 32'h0);

    for (int n = 0; n < 40; n++)
      do_instr(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 2'($urandom),
               $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFD, $urandom);

    imem_ready = 1'b1;
    imem_rdata = 32'hCAFE_F00D;
    do_reset();

    do_instr(0, 0, 2'b00, '0, '0, 32'h13);
    do_instr(1, 0, 2'b01, 32'h22, '0, 32'h0000_0063);
    for (int i = 0; i < 5; i++) begin
      commit      = 1'($urandom);
      imem_ready  = 1'($urandom);
      imem_rdata  = $urandom;
      pc_src      = 2'($urandom);
      pc_plus_imm = $urandom & 32'hFFFF_FFFC;
      tick();
      chk("trapped_flag", trap, 1);
      chk("trapped_addr", trap_addr, 32'h22);
      chk("trapped_pc", pc, 32'h4);
      chk("trapped_instret", instret, 32'd1);
      chk("trapped_req", imem_req, 0);
      chk("trapped_vld", instr_valid, 0);
    end
    do_reset();
    chk("post_trap_clear", trap, 0);
    do_instr(0, 0, 2'b00, '0, '0, 32'h13);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
